// File: rtl/logic16_defs.sv
// Shared definitions for the 16-bit logic stage: operand width, op encodings
// and the bitwise gate functions with their 4-way select.
package logic16_defs;

  localparam int unsigned WIDTH = 16;

  typedef enum logic [1:0] {
    OP_NOT  = 2'b00,
    OP_AND  = 2'b01,
    OP_OR   = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  function automatic logic [WIDTH-1:0] not16(input logic [WIDTH-1:0] x);
    return ~x;
  endfunction

  function automatic logic [WIDTH-1:0] and16(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
    return x & y;
  endfunction

  function automatic logic [WIDTH-1:0] or16(input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y);
    return x | y;
  endfunction

  function automatic logic [WIDTH-1:0] logic16_sel(input op_e o,
                                                   input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    unique case (o)
      OP_NOT:  r = not16(x);
      OP_AND:  r = and16(x, y);
      OP_OR:   r = or16(x, y);
      OP_PASS: r = x;
      default: r = x;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fifo2_16.sv
// Two-entry FIFO with 1-bit wrapping pointers and an occupancy count.
// Reads show the head; when empty, the last popped word is held.
module fifo2_16
  import logic16_defs::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic [1:0]    count
);

  logic [DW-1:0] mem [2];
  logic [DW-1:0] hold;
  logic          wptr;
  logic          rptr;
  logic          push;
  logic          pop;

  assign push = wr_en && (count != 2'd2);
  assign pop  = rd_en && (count != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
      hold  <= '0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wr_data;
        wptr      <= ~wptr;
      end
      if (pop) begin
        hold <= mem[rptr];
        rptr <= ~rptr;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // After a pop the read pointer lands on a stale slot, so the empty case
  // presents the word that actually left last.
  assign rd_data = (count == 2'd0) ? hold : mem[rptr];

endmodule

// File: rtl/logic16_pipe.sv
// Registered, valid/ready-handshaked 16-bit bitwise op stage feeding a
// 2-entry result queue. Define LOGIC16_FLAGS_EN to add per-entry zr/ng flags.
module logic16_pipe
  import logic16_defs::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef LOGIC16_FLAGS_EN
  output logic             zr,
  output logic             ng,
`endif
  output logic [1:0]       count
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [WIDTH-1:0] result;
  logic             accept;
  logic             pop;

  assign in_ready  = (count != FULL);
  assign out_valid = (count != 2'd0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign result    = logic16_sel(op_e'(op), a, b);

`ifdef LOGIC16_FLAGS_EN
  localparam int unsigned DW = WIDTH + 2;
  logic [DW-1:0] wr_word;
  logic [DW-1:0] rd_word;

  // Flags travel with each entry so they always match the data they describe.
  assign wr_word  = {(result == '0), result[WIDTH-1], result};
  assign zr       = rd_word[WIDTH+1];
  assign ng       = rd_word[WIDTH];
  assign out_data = rd_word[WIDTH-1:0];
`else
  localparam int unsigned DW = WIDTH;
  logic [DW-1:0] wr_word;
  logic [DW-1:0] rd_word;

  assign wr_word  = result;
  assign out_data = rd_word;
`endif

  fifo2_16 #(
    .DW (DW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept),
    .wr_data (wr_word),
    .rd_en   (pop),
    .rd_data (rd_word),
    .count   (count)
  );

endmodule
